// File: rtl/mips_mem_pkg.sv
// rtl/mips_mem_pkg.sv - shared types and constants for the data-memory path
package mips_mem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } mem_state_e;

    localparam int WORD_BYTES = 4;
    localparam int BE_W       = WORD_BYTES;

    // Store-type codes the MEM stage decodes into byte-lane patterns
    typedef enum logic [1:0] {
        ST_SB = 2'd0,
        ST_SH = 2'd1,
        ST_SW = 2'd2
    } store_type_e;

    localparam logic [BE_W-1:0] BE_SB = 4'b0001;
    localparam logic [BE_W-1:0] BE_SH = 4'b0011;
    localparam logic [BE_W-1:0] BE_SW = 4'b1111;

    // Lane pattern for a store, shifted to the byte offset within the word
    function automatic logic [BE_W-1:0] store_be(input store_type_e st, input logic [1:0] off);
        logic [BE_W-1:0] base;
        case (st)
            ST_SB:   base = BE_SB;
            ST_SH:   base = BE_SH;
            default: base = BE_SW;
        endcase
        return base << off;
    endfunction

endpackage

// File: rtl/dmem_ram_sp.sv
// rtl/dmem_ram_sp.sv - single-port synchronous word RAM with byte-write enables
module dmem_ram_sp
    import mips_mem_pkg::*;
#(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic            clk,
    input  logic            en_i,
    input  logic            we_i,
    input  logic [BE_W-1:0] be_i,
    input  logic [AW-1:0]   addr_i,
    input  logic [31:0]     wdata_i,
    output logic [31:0]     rdata_o
);

    logic [31:0] mem_q [DEPTH];
    logic [31:0] rdata_q;

    // One access per enabled edge: lane-masked write or registered read
    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i) begin
                for (int l = 0; l < BE_W; l++) begin
                    if (be_i[l]) begin
                        mem_q[addr_i][8*l +: 8] <= wdata_i[8*l +: 8];
                    end
                end
            end else begin
                rdata_q <= mem_q[addr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/data_mem_responder.sv
// rtl/data_mem_responder.sv - fixed-latency load/store responder for the MEM stage
module data_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int          DEPTH     = 32,
    parameter int          LATENCY   = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            req_valid,
    input  logic            req_we,
    input  logic [31:0]     req_addr,
    input  logic [31:0]     req_wdata,
    input  logic [BE_W-1:0] req_be,
    output logic            req_ready,
    output logic            resp_valid,
    output logic [31:0]     resp_rdata,
    output logic            resp_err,
    output logic            stall_mem
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    // WAIT is entered with LATENCY-2 so that its final cycle is the one where the count is 0
    localparam logic [3:0] CNT_INIT = (LATENCY > 1) ? 4'(LATENCY - 2) : 4'd0;

    mem_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;

    logic            we_q;
    logic            err_q;
    logic [AW-1:0]   idx_q;
    logic [31:0]     wdata_q;
    logic [BE_W-1:0] be_q;
    logic            resp_err_q, resp_err_d;

    // BASE_ADDR is word aligned, so the word offset is the difference of the word addresses
    logic [29:0]   req_word;
    logic [AW-1:0] req_idx;
    logic          req_err;

    // Request that reaches the RAM: live inputs on a LATENCY=1 acceptance, captured copy otherwise
    logic            cur_we;
    logic            cur_err;
    logic [AW-1:0]   cur_idx;
    logic [31:0]     cur_wdata;
    logic [BE_W-1:0] cur_be;
    logic            enter_resp;
    logic            ram_en;
    logic [31:0]     ram_rdata;

    assign req_word = req_addr[31:2] - BASE_ADDR[31:2];
    assign req_idx  = req_word[AW-1:0];
    assign req_err  = (req_addr[1:0] != 2'b00) || (req_addr < BASE_ADDR) ||
                      ({2'b00, req_word} >= 32'(DEPTH));

    // Next state, counter and handshake outputs
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        req_ready = 1'b0;
        stall_mem = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    stall_mem = 1'b1;
                    state_d   = (LATENCY > 1) ? WAIT : RESP;
                    cnt_d     = CNT_INIT;
                end
            end
            WAIT: begin
                stall_mem = 1'b1;
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Select the request that is committed/read on the edge entering RESP
    always_comb begin
        cur_we     = we_q;
        cur_err    = err_q;
        cur_idx    = idx_q;
        cur_wdata  = wdata_q;
        cur_be     = be_q;
        if (state_q == IDLE) begin
            cur_we    = req_we;
            cur_err   = req_err;
            cur_idx   = req_idx;
            cur_wdata = req_wdata;
            cur_be    = req_be;
        end
        enter_resp = (state_d == RESP) && (state_q != RESP);
        ram_en     = enter_resp && !cur_err;
        resp_err_d = enter_resp && cur_err;
    end

    // State, counter and registered error flag
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= 4'd0;
            resp_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            resp_err_q <= resp_err_d;
        end
    end

    // Capture the accepted request; reset discards any pending store
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we_q    <= 1'b0;
            err_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (state_q == IDLE && req_valid) begin
            we_q    <= req_we;
            err_q   <= req_err;
            idx_q   <= req_idx;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    dmem_ram_sp #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (cur_we),
        .be_i    (cur_be),
        .addr_i  (cur_idx),
        .wdata_i (cur_wdata),
        .rdata_o (ram_rdata)
    );

    assign resp_valid = (state_q == RESP);
    assign resp_err   = resp_err_q;
    // RAM output register is only meaningful for a good load in RESP
    assign resp_rdata = (resp_valid && !we_q && !err_q) ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_data_mem_responder.sv
// tb/tb_data_mem_responder.sv - self-checking bench for data_mem_responder
module tb_data_mem_responder;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [2:0]       rv    = '0;
    logic [2:0]       we    = '0;
    logic [2:0][31:0] addr  = '0;
    logic [2:0][31:0] wdata = '0;
    logic [2:0][3:0]  be    = '0;
    logic [2:0]       ready;
    logic [2:0]       rvld;
    logic [2:0][31:0] rdata;
    logic [2:0]       err;
    logic [2:0]       stl;

    int errors = 0;
    int checks = 0;

    int          lat_p  [3] = '{2, 1, 2};
    logic [31:0] base_p [3] = '{32'h0, 32'h0, 32'h1000_0000};

    always #5 clk = ~clk;

    data_mem_responder #(.DEPTH(32), .LATENCY(2), .BASE_ADDR(32'h0000_0000)) u0 (
        .clk(clk), .rst(rst), .req_valid(rv[0]), .req_we(we[0]), .req_addr(addr[0]),
        .req_wdata(wdata[0]), .req_be(be[0]), .req_ready(ready[0]), .resp_valid(rvld[0]),
        .resp_rdata(rdata[0]), .resp_err(err[0]), .stall_mem(stl[0]));

    data_mem_responder #(.DEPTH(32), .LATENCY(1), .BASE_ADDR(32'h0000_0000)) u1 (
        .clk(clk), .rst(rst), .req_valid(rv[1]), .req_we(we[1]), .req_addr(addr[1]),
        .req_wdata(wdata[1]), .req_be(be[1]), .req_ready(ready[1]), .resp_valid(rvld[1]),
        .resp_rdata(rdata[1]), .resp_err(err[1]), .stall_mem(stl[1]));

    data_mem_responder #(.DEPTH(32), .LATENCY(2), .BASE_ADDR(32'h1000_0000)) u2 (
        .clk(clk), .rst(rst), .req_valid(rv[2]), .req_we(we[2]), .req_addr(addr[2]),
        .req_wdata(wdata[2]), .req_be(be[2]), .req_ready(ready[2]), .resp_valid(rvld[2]),
        .resp_rdata(rdata[2]), .resp_err(err[2]), .stall_mem(stl[2]));

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
        end
    endtask

    // Transaction-level model: memory image plus edges elapsed since acceptance
    logic [31:0] mm [3][32];
    bit          busy  [3] = '{0, 0, 0};
    int          k     [3] = '{0, 0, 0};
    bit          m_we  [3];
    logic [31:0] m_addr[3];
    logic [31:0] m_wd  [3];
    logic [3:0]  m_be  [3];
    bit          m_err [3];
    logic [31:0] exp_rd [3];
    bit          exp_err[3];

    function automatic bit addr_bad(input int i, input logic [31:0] a);
        logic [31:0] off;
        off = a - base_p[i];
        return (a[1:0] != 2'b00) || (a < base_p[i]) || ((off >> 2) >= 32);
    endfunction

    task automatic complete(input int i);
        logic [31:0] off;
        int idx;
        off = m_addr[i] - base_p[i];
        idx = int'(off[6:2]);
        exp_err[i] = m_err[i];
        exp_rd[i]  = 32'h0;
        if (!m_err[i]) begin
            if (m_we[i]) begin
                for (int l = 0; l < 4; l++)
                    if (m_be[i][l]) mm[i][idx][8*l +: 8] = m_wd[i][8*l +: 8];
            end else begin
                exp_rd[i] = mm[i][idx];
            end
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or negedge rst);
            for (int i = 0; i < 3; i++) begin
                if (!rst) begin
                    busy[i] = 0;
                    k[i]    = 0;
                end else if (!busy[i]) begin
                    if (rv[i]) begin
                        busy[i]   = 1;
                        k[i]      = 1;
                        m_we[i]   = we[i];
                        m_addr[i] = addr[i];
                        m_wd[i]   = wdata[i];
                        m_be[i]   = be[i];
                        m_err[i]  = addr_bad(i, addr[i]);
                        if (lat_p[i] == 1) complete(i);
                    end
                end else if (k[i] == lat_p[i]) begin
                    busy[i] = 0;
                end else begin
                    k[i] = k[i] + 1;
                    if (k[i] == lat_p[i]) complete(i);
                end
            end
        end
    end

    // Every cycle, every instance: outputs against the model
    initial begin
        bit e_resp;
        bit e_stall;
        forever begin
            @(negedge clk);
            for (int i = 0; i < 3; i++) begin
                e_resp  = busy[i] && (k[i] == lat_p[i]);
                e_stall = (!busy[i] && rv[i]) || (busy[i] && (k[i] < lat_p[i]));
                chk($sformatf("u%0d req_ready", i), 32'(ready[i]), 32'(!busy[i]));
                chk($sformatf("u%0d resp_valid", i), 32'(rvld[i]), 32'(e_resp));
                chk($sformatf("u%0d stall_mem", i), 32'(stl[i]), 32'(e_stall));
                chk($sformatf("u%0d resp_rdata", i), rdata[i], e_resp ? exp_rd[i] : 32'h0);
                chk($sformatf("u%0d resp_err", i), 32'(err[i]), e_resp ? 32'(exp_err[i]) : 32'h0);
            end
        end
    end

    task automatic access(input int i, input bit w, input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] b, output logic [31:0] rd, output bit e,
                          output int lat, output int stalls);
        bit got;
        @(posedge clk);
        #1;
        rv[i] = 1'b1; we[i] = w; addr[i] = a; wdata[i] = wd; be[i] = b;
        @(negedge clk);
        stalls = int'(stl[i]);
        @(posedge clk);
        #1;
        rv[i] = 1'b0;
        lat = 1;
        got = 0;
        rd  = 32'hX;
        e   = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (stl[i]) stalls++;
            if (rvld[i]) begin
                rd  = rdata[i];
                e   = err[i];
                got = 1;
                break;
            end
            @(posedge clk);
            lat++;
        end
        chk($sformatf("u%0d response within bound", i), 32'(got), 32'd1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] rd;
        bit          e;
        int          lat, st, acc;
        logic        rdy_s [4];
        logic        rsp_s [4];

        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("u%0d reset ready", i), 32'(ready[i]), 32'd1);
            chk($sformatf("u%0d reset stall", i), 32'(stl[i]), 32'd0);
            chk($sformatf("u%0d reset resp_valid", i), 32'(rvld[i]), 32'd0);
        end

        // Fill every word with a known pattern
        for (int i = 0; i < 3; i++)
            for (int w = 0; w < 32; w++)
                access(i, 1, base_p[i] + 32'(4 * w), {8'h5A, 8'(i), 8'(w), 8'h3C}, 4'hF, rd, e, lat, st);

        // Load after preload of word 2
        access(0, 1, 32'h08, 32'hDEADBEEF, 4'hF, rd, e, lat, st);
        access(0, 0, 32'h08, 32'h0, 4'h0, rd, e, lat, st);
        chk("load 0x08 rdata", rd, 32'hDEADBEEF);
        chk("load 0x08 err", 32'(e), 32'd0);
        chk("load 0x08 latency", 32'(lat), 32'd2);
        chk("load 0x08 stall cycles", 32'(st), 32'd2);

        // Partial byte-enable store
        access(0, 1, 32'h0C, 32'hAABBCCDD, 4'hF, rd, e, lat, st);
        access(0, 1, 32'h0C, 32'h11223344, 4'b0101, rd, e, lat, st);
        chk("store 0x0C rdata", rd, 32'h0);
        chk("store 0x0C err", 32'(e), 32'd0);
        access(0, 0, 32'h0C, 32'h0, 4'h0, rd, e, lat, st);
        chk("merged 0x0C", rd, 32'hAA22CC44);

        // Empty byte enable still answers and writes nothing
        access(0, 1, 32'h0C, 32'hFFFFFFFF, 4'b0000, rd, e, lat, st);
        access(0, 0, 32'h0C, 32'h0, 4'h0, rd, e, lat, st);
        chk("be=0 leaves 0x0C", rd, 32'hAA22CC44);

        // Bad addresses
        access(0, 1, 32'h04, 32'h12345678, 4'hF, rd, e, lat, st);
        access(0, 1, 32'h06, 32'hFFFFFFFF, 4'hF, rd, e, lat, st);
        chk("misaligned err", 32'(e), 32'd1);
        chk("misaligned rdata", rd, 32'h0);
        access(0, 0, 32'h80, 32'h0, 4'h0, rd, e, lat, st);
        chk("out of range err", 32'(e), 32'd1);
        chk("out of range rdata", rd, 32'h0);
        access(0, 0, 32'h04, 32'h0, 4'h0, rd, e, lat, st);
        chk("word 1 unchanged", rd, 32'h12345678);

        // LATENCY=1 single access and back-to-back with req_valid held
        access(1, 0, 32'h08, 32'h0, 4'h0, rd, e, lat, st);
        chk("lat1 rdata", rd, 32'h5A01023C);
        chk("lat1 latency", 32'(lat), 32'd1);
        chk("lat1 stall cycles", 32'(st), 32'd1);
        @(posedge clk);
        #1;
        rv[1] = 1'b1; we[1] = 1'b0; addr[1] = 32'h10; be[1] = 4'h0;
        acc = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            rdy_s[c] = ready[1];
            rsp_s[c] = rvld[1];
            if (ready[1] && rv[1]) acc++;
            if (c == 3) rv[1] = 1'b0;
        end
        chk("b2b ready c0", 32'(rdy_s[0]), 32'd1);
        chk("b2b ready c1", 32'(rdy_s[1]), 32'd0);
        chk("b2b ready c2", 32'(rdy_s[2]), 32'd1);
        chk("b2b ready c3", 32'(rdy_s[3]), 32'd0);
        chk("b2b resp c1", 32'(rsp_s[1]), 32'd1);
        chk("b2b resp c2", 32'(rsp_s[2]), 32'd0);
        chk("b2b resp c3", 32'(rsp_s[3]), 32'd1);
        chk("b2b accepts", 32'(acc), 32'd2);

        // Reset during WAIT of a store discards it
        access(0, 1, 32'h10, 32'h0, 4'hF, rd, e, lat, st);
        @(posedge clk);
        #1;
        rv[0] = 1'b1; we[0] = 1'b1; addr[0] = 32'h10; wdata[0] = 32'hFFFFFFFF; be[0] = 4'hF;
        @(posedge clk);
        #1;
        rv[0] = 1'b0;
        #1;
        chk("wait stall before reset", 32'(stl[0]), 32'd1);
        rst = 1'b0;
        #1;
        chk("async reset resp_valid", 32'(rvld[0]), 32'd0);
        chk("async reset stall", 32'(stl[0]), 32'd0);
        chk("async reset ready", 32'(ready[0]), 32'd1);
        chk("async reset rdata", rdata[0], 32'h0);
        chk("async reset err", 32'(err[0]), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
        access(0, 0, 32'h10, 32'h0, 4'h0, rd, e, lat, st);
        chk("discarded store 0x10", rd, 32'h0);

        // Non-zero base address
        access(2, 0, 32'h1000_007C, 32'h0, 4'h0, rd, e, lat, st);
        chk("base top word err", 32'(e), 32'd0);
        chk("base top word rdata", rd, 32'h5A021F3C);
        access(2, 0, 32'h0FFF_FFFC, 32'h0, 4'h0, rd, e, lat, st);
        chk("below base err", 32'(e), 32'd1);
        chk("below base rdata", rd, 32'h0);
        access(2, 0, 32'h1000_0080, 32'h0, 4'h0, rd, e, lat, st);
        chk("past top err", 32'(e), 32'd1);

        @(posedge clk);
        @(negedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
